// File: rtl/multi_song_timer.sv
// Per-song mm:ss elapsed-play-time counters advanced by a 1 Hz tick enable,
// with per-song seek/load, a configurable minute limit and a wrap pulse.
module multi_song_timer #(
  parameter int NUM_SONGS    = 2,
  parameter int SEL_W        = 1,
  parameter int MIN_W        = 6,
  parameter int MAX_MINS     = 59,
  parameter int CLEAR_OTHERS = 1
) (
  input  logic                       clk,
  input  logic                       RESET_N,
  input  logic                       tick_1hz,
  input  logic [SEL_W-1:0]           ss,
  input  logic                       ispaused,
  input  logic                       load,
  input  logic [MIN_W-1:0]           load_mins,
  input  logic [5:0]                 load_secs,
  output logic [MIN_W-1:0]           cur_mins,
  output logic [5:0]                 cur_secs,
  output logic [NUM_SONGS*MIN_W-1:0] all_mins,
  output logic [NUM_SONGS*6-1:0]     all_secs,
  output logic                       wrap
);

  localparam logic [MIN_W-1:0] MAX_M = MIN_W'(MAX_MINS);
  localparam logic [5:0]       MAX_S = 6'd59;

  logic [MIN_W-1:0] mins     [NUM_SONGS];
  logic [5:0]       secs     [NUM_SONGS];
  logic [MIN_W-1:0] mins_nxt [NUM_SONGS];
  logic [5:0]       secs_nxt [NUM_SONGS];
  logic             wrap_nxt;
  logic             sel_valid;
  logic             counted;

  function automatic logic [5:0] clamp_secs(input logic [5:0] s);
    return (s > MAX_S) ? MAX_S : s;
  endfunction

  function automatic logic [MIN_W-1:0] clamp_mins(input logic [MIN_W-1:0] m);
    return (m > MAX_M) ? MAX_M : m;
  endfunction

  assign sel_valid = (int'(ss) < NUM_SONGS);
  assign counted   = tick_1hz && !ispaused;

  always_comb begin
    wrap_nxt = 1'b0;
    for (int i = 0; i < NUM_SONGS; i++) begin
      mins_nxt[i] = mins[i];
      secs_nxt[i] = secs[i];
      if (sel_valid) begin
        if (i == int'(ss)) begin
          // load wins over a same-cycle tick on the selected channel
          if (load) begin
            mins_nxt[i] = clamp_mins(load_mins);
            secs_nxt[i] = clamp_secs(load_secs);
          end else if (counted) begin
            if (secs[i] != MAX_S) begin
              secs_nxt[i] = secs[i] + 6'd1;
            end else begin
              secs_nxt[i] = '0;
              if (mins[i] != MAX_M) begin
                mins_nxt[i] = mins[i] + MIN_W'(1);
              end else begin
                mins_nxt[i] = '0;
                wrap_nxt    = 1'b1;
              end
            end
          end
        end else if (counted && (CLEAR_OTHERS != 0)) begin
          mins_nxt[i] = '0;
          secs_nxt[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_SONGS; i++) begin
        mins[i] <= '0;
        secs[i] <= '0;
      end
      wrap <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SONGS; i++) begin
        mins[i] <= mins_nxt[i];
        secs[i] <= secs_nxt[i];
      end
      wrap <= wrap_nxt;
    end
  end

  // Selected-channel view follows ss with no register delay
  always_comb begin
    cur_mins = '0;
    cur_secs = '0;
    for (int i = 0; i < NUM_SONGS; i++) begin
      if (sel_valid && (i == int'(ss))) begin
        cur_mins = mins[i];
        cur_secs = secs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SONGS; g++) begin : g_pack
    assign all_mins[g*MIN_W +: MIN_W] = mins[g];
    assign all_secs[g*6 +: 6]         = secs[g];
  end

endmodule

// File: tb/tb_multi_song_timer.sv
// Directed plus randomized bench for multi_song_timer across three configurations,
// checked against a total-seconds reference model.
module tb_multi_song_timer;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       tick_1hz;
  logic       ispaused;
  logic       load;
  logic [5:0] load_mins;
  logic [5:0] load_secs;
  logic       ssab;
  logic [1:0] ss2;

  logic [5:0]  cm0, cs0, cm1, cs1, cm2, cs2;
  logic [11:0] am0, as0, am1, as1;
  logic [17:0] am2, as2;
  logic        w0, w1, w2;

  int vectors     = 0;
  int miscompares = 0;

  // model state: elapsed seconds per (config, channel)
  int t [3][3];
  bit mw [3];

  always #5 clk = ~clk;

  multi_song_timer #(.NUM_SONGS(2), .SEL_W(1), .MIN_W(6), .MAX_MINS(59), .CLEAR_OTHERS(1)) u0 (
    .clk(clk), .RESET_N(RESET_N), .tick_1hz(tick_1hz), .ss(ssab), .ispaused(ispaused),
    .load(load), .load_mins(load_mins), .load_secs(load_secs), .cur_mins(cm0), .cur_secs(cs0),
    .all_mins(am0), .all_secs(as0), .wrap(w0));

  multi_song_timer #(.NUM_SONGS(2), .SEL_W(1), .MIN_W(6), .MAX_MINS(59), .CLEAR_OTHERS(0)) u1 (
    .clk(clk), .RESET_N(RESET_N), .tick_1hz(tick_1hz), .ss(ssab), .ispaused(ispaused),
    .load(load), .load_mins(load_mins), .load_secs(load_secs), .cur_mins(cm1), .cur_secs(cs1),
    .all_mins(am1), .all_secs(as1), .wrap(w1));

  multi_song_timer #(.NUM_SONGS(3), .SEL_W(2), .MIN_W(6), .MAX_MINS(3), .CLEAR_OTHERS(1)) u2 (
    .clk(clk), .RESET_N(RESET_N), .tick_1hz(tick_1hz), .ss(ss2), .ispaused(ispaused),
    .load(load), .load_mins(load_mins), .load_secs(load_secs), .cur_mins(cm2), .cur_secs(cs2),
    .all_mins(am2), .all_secs(as2), .wrap(w2));

  function automatic int nch(input int c);
    return (c == 2) ? 3 : 2;
  endfunction

  function automatic int maxm(input int c);
    return (c == 2) ? 3 : 59;
  endfunction

  function automatic int sel(input int c);
    return (c == 2) ? int'(ss2) : int'(ssab);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mw[c] = 1'b0;
      for (int i = 0; i < 3; i++) t[c][i] = 0;
    end
  endtask

  task automatic model_edge();
    if (!RESET_N) begin
      model_reset();
    end else begin
      for (int c = 0; c < 3; c++) begin
        int s      = sel(c);
        int period = (maxm(c) + 1) * 60;
        bit cnt    = tick_1hz && !ispaused;
        bit nw     = 1'b0;
        if (s < nch(c)) begin
          if (load) begin
            t[c][s] = imin(int'(load_mins), maxm(c)) * 60 + imin(int'(load_secs), 59);
          end else if (cnt) begin
            if (t[c][s] == period - 1) nw = 1'b1;
            t[c][s] = (t[c][s] + 1) % period;
          end
          if (cnt && c != 1) begin
            for (int i = 0; i < nch(c); i++) if (i != s) t[c][i] = 0;
          end
        end
        mw[c] = nw;
      end
    end
  endtask

  function automatic int obs_cm(input int c);
    case (c)
      0: return int'(cm0);
      1: return int'(cm1);
      default: return int'(cm2);
    endcase
  endfunction

  function automatic int obs_cs(input int c);
    case (c)
      0: return int'(cs0);
      1: return int'(cs1);
      default: return int'(cs2);
    endcase
  endfunction

  function automatic int obs_w(input int c);
    case (c)
      0: return int'(w0);
      1: return int'(w1);
      default: return int'(w2);
    endcase
  endfunction

  function automatic int obs_am(input int c, input int ch);
    case (c)
      0: return int'(am0[ch*6 +: 6]);
      1: return int'(am1[ch*6 +: 6]);
      default: return int'(am2[ch*6 +: 6]);
    endcase
  endfunction

  function automatic int obs_as(input int c, input int ch);
    case (c)
      0: return int'(as0[ch*6 +: 6]);
      1: return int'(as1[ch*6 +: 6]);
      default: return int'(as2[ch*6 +: 6]);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      int s    = sel(c);
      int em   = (s < nch(c)) ? t[c][s] / 60 : 0;
      int es   = (s < nch(c)) ? t[c][s] % 60 : 0;
      chk($sformatf("cfg%0d cur_mins", c), obs_cm(c), em);
      chk($sformatf("cfg%0d cur_secs", c), obs_cs(c), es);
      chk($sformatf("cfg%0d wrap", c), obs_w(c), int'(mw[c]));
      for (int i = 0; i < nch(c); i++) begin
        chk($sformatf("cfg%0d ch%0d mins", c, i), obs_am(c, i), t[c][i] / 60);
        chk($sformatf("cfg%0d ch%0d secs", c, i), obs_as(c, i), t[c][i] % 60);
      end
    end
  endtask

  task automatic step(input bit tk, input bit ld);
    tick_1hz = tk;
    load     = ld;
    @(posedge clk);
    model_edge();
    #1;
    tick_1hz = 1'b0;
    load     = 1'b0;
    check_all();
  endtask

  initial begin
    RESET_N   = 1'b0;
    tick_1hz  = 1'b0;
    ispaused  = 1'b0;
    load      = 1'b0;
    load_mins = '0;
    load_secs = '0;
    ssab      = 1'b0;
    ss2       = 2'd0;
    model_reset();
    #12;
    check_all();
    RESET_N = 1'b1;

    // 61 counted ticks on song 0
    for (int n = 0; n < 61; n++) step(1'b1, 1'b0);
    chk("count61 cur_mins", int'(cm0), 1);
    chk("count61 cur_secs", int'(cs0), 1);
    chk("count61 ch1 secs", int'(as0[11:6]), 0);

    // asynchronous reset mid-run, observed before any clock edge
    for (int n = 0; n < 3; n++) step(1'b1, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async rst cur_secs", int'(cs0), 0);
    step(1'b1, 1'b0);
    load_mins = 6'd5;
    step(1'b1, 1'b1);
    RESET_N = 1'b1;
    step(1'b0, 1'b0);

    // seek to the limit and roll over
    load_mins = 6'd59;
    load_secs = 6'd58;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("seek 59:59 mins", int'(cm0), 59);
    chk("seek 59:59 secs", int'(cs0), 59);
    chk("seek no wrap yet", int'(w0), 0);
    step(1'b1, 1'b0);
    chk("rollover secs", int'(cs0), 0);
    chk("wrap high", int'(w0), 1);
    step(1'b0, 1'b0);
    chk("wrap one cycle", int'(w0), 0);

    // clear-vs-resume of the unselected song
    load_mins = 6'd0;
    load_secs = 6'd10;
    step(1'b0, 1'b1);
    ssab = 1'b1;
    ss2  = 2'd1;
    step(1'b1, 1'b0);
    chk("clr ch1 secs", int'(as0[11:6]), 1);
    chk("clr ch0 secs", int'(as0[5:0]), 0);
    chk("hold ch0 secs", int'(as1[5:0]), 10);
    ssab = 1'b0;
    ss2  = 2'd0;
    step(1'b1, 1'b0);
    chk("resume cur_secs", int'(cs1), 11);
    chk("cleared restart", int'(cs0), 1);

    // pause blocks counting and clearing but not load
    ispaused = 1'b1;
    ssab     = 1'b1;
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0);
    chk("pause other held", int'(as0[5:0]), 1);
    load_mins = 6'd3;
    load_secs = 6'd20;
    step(1'b1, 1'b1);
    chk("paused load mins", int'(cm0), 3);
    chk("paused load secs", int'(cs0), 20);
    ispaused = 1'b0;
    step(1'b1, 1'b0);
    chk("unpause secs", int'(cs0), 21);

    // clamped load beats a same-cycle tick
    load_mins = 6'd63;
    load_secs = 6'd63;
    step(1'b1, 1'b1);
    chk("clamp mins", int'(cm0), 59);
    chk("clamp secs", int'(cs0), 59);
    chk("clamp no wrap", int'(w0), 0);

    // out-of-range select on the three-song instance
    ss2       = 2'd3;
    load_mins = 6'd1;
    load_secs = 6'd1;
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("bad sel cur_mins", int'(cm2), 0);
    chk("bad sel cur_secs", int'(cs2), 0);
    chk("bad sel wrap", int'(w2), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) ssab = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) ss2 = 2'($urandom_range(3));
      ispaused  = ($urandom_range(5) == 0);
      load_mins = 6'($urandom_range(63));
      load_secs = 6'($urandom_range(63));
      if ($urandom_range(999) == 0) begin
        RESET_N = 1'b0;
        #1;
        model_reset();
        check_all();
        RESET_N = 1'b1;
      end
      step(1'($urandom_range(1)), ($urandom_range(19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
